// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter that shares the single L1->L2 request port between two L1 masters.
// Each master owns a one-deep request slot. Buffered requests go to L2 one at a time, and each
// completion is routed back to the master that issued it.
module l2_port_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned L1_BLOCK_SIZE = 16,
  localparam int unsigned BW           = L1_BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [BW-1:0]         m0_wdata,
  output logic [BW-1:0]         m0_rdata,
  output logic                  m0_ready,
  output logic                  m0_hit,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [BW-1:0]         m1_wdata,
  output logic [BW-1:0]         m1_rdata,
  output logic                  m1_ready,
  output logic                  m1_hit,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [BW-1:0]         l2_wdata,
  input  logic [BW-1:0]         l2_rdata,
  input  logic                  l2_ready,
  input  logic                  l2_hit,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic [1:0]            pend_q, pend_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] slot_addr_q [2];
  logic [ADDR_WIDTH-1:0] slot_addr_d [2];
  logic [BW-1:0]         slot_wdata_q [2];
  logic [BW-1:0]         slot_wdata_d [2];
  logic [1:0]            slot_wr_q, slot_wr_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] l2_addr_q, l2_addr_d;
  logic [BW-1:0]         l2_wdata_q, l2_wdata_d;
  logic                  l2_read_q, l2_read_d;
  logic                  l2_write_q, l2_write_d;
  logic                  busy_q, busy_d;
  logic [BW-1:0]         rdata_q [2];
  logic [BW-1:0]         rdata_d [2];
  logic [1:0]            ready_q, ready_d;
  logic [1:0]            hit_q, hit_d;

  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [BW-1:0]         req_wdata [2];
  logic [1:0]            req_any, req_wr;
  logic                  sel;

  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;
  assign req_any      = {m1_read | m1_write, m0_read | m0_write};
  // Read and write together is treated as a write.
  assign req_wr       = {m1_write, m0_write};

  // Next state: slot capture, arbitration, strobe generation and completion routing.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    last_d       = last_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    slot_wr_d    = slot_wr_q;
    owner_d      = owner_q;
    l2_addr_d    = l2_addr_q;
    l2_wdata_d   = l2_wdata_q;
    l2_read_d    = 1'b0;
    l2_write_d   = 1'b0;
    busy_d       = busy_q;
    rdata_d      = rdata_q;
    ready_d      = 2'b00;
    hit_d        = hit_q;
    sel          = 1'b0;

    // A full slot ignores new requests, including on the edge that empties it.
    for (int n = 0; n < 2; n++) begin
      if (req_any[n] && !pend_q[n]) begin
        slot_addr_d[n]  = req_addr[n];
        slot_wdata_d[n] = req_wdata[n];
        slot_wr_d[n]    = req_wr[n];
        pend_d[n]       = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          sel        = (pend_q == 2'b11) ? ~last_q : pend_q[1];
          owner_d    = sel;
          l2_addr_d  = slot_addr_q[sel];
          l2_wdata_d = slot_wdata_q[sel];
          l2_write_d = slot_wr_q[sel];
          l2_read_d  = ~slot_wr_q[sel];
          busy_d     = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue, StWait: begin
        if (l2_ready) begin
          if (!slot_wr_q[owner_q]) rdata_d[owner_q] = l2_rdata;
          hit_d[owner_q]   = l2_hit;
          ready_d[owner_q] = 1'b1;
          pend_d[owner_q]  = 1'b0;
          last_d           = owner_q;
          busy_d           = 1'b0;
          state_d          = StIdle;
        end else begin
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      pend_q          <= 2'b00;
      last_q          <= 1'b1;
      slot_addr_q[0]  <= '0;
      slot_addr_q[1]  <= '0;
      slot_wdata_q[0] <= '0;
      slot_wdata_q[1] <= '0;
      slot_wr_q       <= 2'b00;
      owner_q         <= 1'b0;
      l2_addr_q       <= '0;
      l2_wdata_q      <= '0;
      l2_read_q       <= 1'b0;
      l2_write_q      <= 1'b0;
      busy_q          <= 1'b0;
      rdata_q[0]      <= '0;
      rdata_q[1]      <= '0;
      ready_q         <= 2'b00;
      hit_q           <= 2'b00;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      last_q       <= last_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_wr_q    <= slot_wr_d;
      owner_q      <= owner_d;
      l2_addr_q    <= l2_addr_d;
      l2_wdata_q   <= l2_wdata_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      busy_q       <= busy_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      hit_q        <= hit_d;
    end
  end

  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign m0_ready = ready_q[0];
  assign m1_ready = ready_q[1];
  assign m0_hit   = hit_q[0];
  assign m1_hit   = hit_q[1];
  assign l2_addr  = l2_addr_q;
  assign l2_wdata = l2_wdata_q;
  assign l2_read  = l2_read_q;
  assign l2_write = l2_write_q;
  assign busy     = busy_q;
  assign owner    = owner_q;

endmodule
